// File: rtl/counter_bank_pkg.sv
// Shared types for the multi-channel event counter bank.
// Mode encoding and select-width helper used by bank and lanes.
package counter_bank_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } count_mode_e;

    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/counter_lane.sv
// One counter channel: clear/load/increment with wrap or saturate,
// plus its registered one-cycle terminal-count pulse.
module counter_lane
    import counter_bank_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  count_mode_e      mode,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    localparam logic [WIDTH-1:0] C_MAX = '1;
    localparam logic [WIDTH-1:0] C_PRE = C_MAX - 1'b1;

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             w_at_max;
    logic             w_pre_max;

    assign w_at_max  = (r_count == C_MAX);
    assign w_pre_max = (r_count == C_PRE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
            r_tc    <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            if (clr) begin
                r_count <= '0;
            end else if (load) begin
                r_count <= load_val;
            end else if (inc) begin
                // Saturated lane holds MAX silently; tc only on arrival.
                if (mode == MODE_SAT) begin
                    if (!w_at_max) begin
                        r_count <= r_count + 1'b1;
                        r_tc    <= w_pre_max;
                    end
                end else begin
                    r_count <= r_count + 1'b1;
                    r_tc    <= w_at_max;
                end
            end
        end
    end

    assign count = r_count;
    assign tc    = r_tc;

endmodule

// File: rtl/counter_bank.sv
// Bank of independent event counters with indexed load
// and a registered read port.
module counter_bank
    import counter_bank_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SELW     = sel_w(CHANNELS)
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [CHANNELS-1:0]       inc,
    input  logic [CHANNELS-1:0]       clr,
    input  logic [CHANNELS-1:0]       mode,
    input  logic                      load_en,
    input  logic [SELW-1:0]           load_sel,
    input  logic [WIDTH-1:0]          load_val,
    input  logic [SELW-1:0]           rd_sel,
    output logic [WIDTH-1:0]          rd_val,
    output logic [CHANNELS-1:0]       tc,
    output logic [CHANNELS*WIDTH-1:0] count
);

    logic [CHANNELS-1:0] w_load;
    logic [WIDTH-1:0]    w_rd;
    logic [WIDTH-1:0]    r_rd_val;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        assign w_load[g] = load_en && (load_sel == SELW'(g));

        counter_lane #(
            .WIDTH (WIDTH)
        ) u_lane (
            .clock    (clock),
            .reset_n  (reset_n),
            .inc      (inc[g]),
            .clr      (clr[g]),
            .load     (w_load[g]),
            .load_val (load_val),
            .mode     (count_mode_e'(mode[g])),
            .count    (count[g*WIDTH +: WIDTH]),
            .tc       (tc[g])
        );
    end

    // Out-of-range selects fall through to zero.
    always_comb begin
        w_rd = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (rd_sel == SELW'(i)) begin
                w_rd = count[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_val <= '0;
        end else begin
            r_rd_val <= w_rd;
        end
    end

    assign rd_val = r_rd_val;

endmodule

// File: doc/counter_bank.md
# counter_bank

Parametrised multi-channel event counter bank, the successor to the single free-running 8-bit submodule counter. Holds `CHANNELS` independent `WIDTH`-bit counters, each with increment, synchronous clear, indexed parallel load and a per-channel wrap/saturate mode. Each channel raises a one-cycle terminal-count pulse. A registered read port selects one counter. Used as a statistics/event block instantiated inside a parent module, with its ticks driven by the parent's tock logic.

## Interface
Parameters:
- `WIDTH`, 8, counter width in bits (≥2)
- `CHANNELS`, 4, number of counters (≥1, need not be a power of 2)
- `SELW`, `$clog2(CHANNELS)` (min 1), channel-select width; derived, not overridden

Ports:
- `clock`  in  1  sole clock; all state updates on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `inc`  in  CHANNELS  per-channel increment request, sampled each edge
- `clr`  in  CHANNELS  per-channel synchronous clear
- `mode`  in  CHANNELS  per-channel mode: 0 = wrap, 1 = saturate
- `load_en`  in  1  load `load_val` into channel `load_sel`
- `load_sel`  in  SELW  load target channel
- `load_val`  in  WIDTH  load value
- `rd_sel`  in  SELW  read channel select
- `rd_val`  out  WIDTH  registered read data
- `tc`  out  CHANNELS  per-channel terminal-count pulse, registered
- `count`  out  CHANNELS*WIDTH  flat view of all counters; channel i at bits [i*WIDTH +: WIDTH]

## Operation
- Reset (`reset_n`=0, asynchronous assert): all counters = 0, `tc` = 0, `rd_val` = 0. Reset is held while low. The first update occurs on the first rising edge after `reset_n` rises. Reset mid-operation discards all counts and any pending pulse.
- Per-channel priority at each edge: `clr` > load (when `load_en` and `load_sel` == i) > `inc` > hold.
- Wrap mode, inc: count ← count + 1 mod 2^WIDTH. When count was MAX (2^WIDTH−1), count → 0 and `tc[i]` = 1 for the next cycle.
- Saturate mode, inc: count ← min(count+1, MAX). `tc[i]` pulses only on the transition MAX−1 → MAX. Inc while at MAX holds MAX with `tc`=0.
- Clear or load never raises `tc`, including a load of MAX. A clear or load in the same cycle as an inc suppresses both the inc and its `tc`.
- `load_sel` ≥ CHANNELS: load ignored. `rd_sel` ≥ CHANNELS: `rd_val` ← 0.
- `mode` is sampled every edge and may change at any time. A saturated counter switched to wrap mode wraps on its next inc.
- Channels are fully independent. Simultaneous events on different channels all take effect in the same edge.

## Timing
- Counter update latency: 1 cycle. `count` reflects the edge at which `inc`, `clr` or load was sampled.
- `tc[i]` is high for exactly the one cycle following the wrapping or saturating edge. A channel incrementing every cycle at WIDTH=8 pulses once every 256 cycles.
- `rd_val` ← `count[rd_sel]` using the pre-edge value, so same-edge updates are not visible. Read latency is 1 cycle from `rd_sel`. With `rd_sel` constant, `rd_val` trails `count` by 1 cycle.
- No combinational path from any input to any output.

## Structure
- Package `counter_bank_pkg`: enum `count_mode_e` {MODE_WRAP=0, MODE_SAT=1}. `counter_lane` takes `mode` as `count_mode_e`; the bank port stays a plain CHANNELS-bit vector.
- Sub-module `counter_lane` (params `WIDTH`; ports `clock`, `reset_n`, `inc`, `clr`, `load`, `load_val`, `mode`, `count`, `tc`) holds one counter and its tc register. It is instantiated CHANNELS times in a generate loop.
- `counter_bank` holds the load decode, the read mux and the `rd_val` register.

## Test plan
- Reset: drive activity, pull `reset_n` low between edges. All outputs are 0 immediately (asynchronously), and the counts stay 0 for 3 edges after release with `inc`=0.
- Wrap: WIDTH=8, ch0 wrap, `inc[0]`=1 for 256 cycles. Count goes 0→255→0, and `tc[0]`=1 only in the cycle after the 255→0 edge.
- Saturate: ch1 sat, load 253, then 4 incs. Counts are 254, 255, 255, 255, with `tc[1]` pulsing once after the 254→255 edge.
- Priority: on ch2, assert `clr`, load 0x40 and `inc` in one cycle, giving count 0. Next cycle load 0x40 with inc gives 0x40. Next inc gives 0x41. `tc` stays 0 throughout.
- Read port: CHANNELS=3, `rd_sel`=1 while inc'ing ch1 from 5, so `rd_val` shows 5 while `count` shows 6. `rd_sel`=3 gives `rd_val`=0 next cycle. `load_sel`=3 leaves all channels unchanged.
- Independence: all channels inc together with ch0 wrap at MAX and ch3 sat at MAX−1. Same edge: ch0 → 0 and ch3 → MAX, with `tc`=4'b1001.
